// File: rtl/sc_spi_target.sv
// SPI target endpoint: oversamples CSB/SCLK/MOSI in the SYSCLK domain and exchanges
// right-justified words with an on-chip client over valid/ready streams.
module sc_spi_target #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      SYSCLK,
    input  logic                      SYSRSTB,
    input  logic                      CPOL,
    input  logic                      CPHA,
    input  logic                      BORDER,
    input  logic [$clog2(DATA_W):0]   DWIDTH,
    input  logic                      CSB,
    input  logic                      SCLK,
    input  logic                      MOSI,
    output logic                      MISO,
    output logic                      MISO_OE,
    input  logic [DATA_W-1:0]         TXDATA,
    input  logic                      TXVALID,
    output logic                      TXREADY,
    output logic [DATA_W-1:0]         RXDATA,
    output logic                      RXVALID,
    input  logic                      RXREADY,
    output logic                      RXOVF,
    output logic                      TXUNF,
    output logic                      BUSY
);

    localparam int CW = $clog2(DATA_W) + 1;
    localparam int IW = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   csb_prev_q, csb_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic                   border_q, border_d;
    logic [CW-1:0]          dw_q, dw_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]      rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]      tx_sh_q, tx_sh_d;
    logic                   skip_q, skip_d;
    logic                   done_q, done_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_W-1:0]      rxdata_q, rxdata_d;
    logic                   rxvalid_q, rxvalid_d;
    logic                   rxovf_q, rxovf_d;
    logic                   txunf_q, txunf_d;

    logic              csb_s, sclk_s, mosi_s;
    logic              csb_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic              word_start;
    logic [CW-1:0]     dw_eff;
    logic [IW-1:0]     msb_idx;
    logic              tx_bit;

    assign csb_s  = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign csb_fall    = csb_prev_q & ~csb_s;
    assign lead_edge   = (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
    assign trail_edge  = (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;

    assign dw_eff  = (DWIDTH == '0 || DWIDTH > CW'(DATA_W)) ? CW'(DATA_W) : DWIDTH;
    assign msb_idx = IW'(dw_q - CW'(1));
    assign tx_bit  = border_q ? tx_sh_q[msb_idx] : tx_sh_q[0];

    assign MISO    = (state_q == ACTIVE) & tx_bit;
    assign MISO_OE = (state_q == ACTIVE);
    assign BUSY    = (state_q == ACTIVE);
    assign TXREADY = ~hold_full_q;
    assign RXDATA  = rxdata_q;
    assign RXVALID = rxvalid_q;
    assign RXOVF   = rxovf_q;
    assign TXUNF   = txunf_q;

    always_comb begin
        state_d     = state_q;
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], CSB};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        csb_prev_d  = csb_s;
        sclk_prev_d = sclk_s;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        border_d    = border_q;
        dw_d        = dw_q;
        cnt_d       = cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        skip_d      = skip_q;
        done_d      = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rxdata_d    = rxdata_q;
        rxvalid_d   = rxvalid_q;
        rxovf_d     = 1'b0;
        txunf_d     = 1'b0;
        word_start  = 1'b0;

        if (rxvalid_q && RXREADY) begin
            rxvalid_d = 1'b0;
        end
        if (TXVALID && !hold_full_q) begin
            hold_d      = TXDATA;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (csb_fall) begin
                    state_d    = ACTIVE;
                    cpol_d     = CPOL;
                    cpha_d     = CPHA;
                    border_d   = BORDER;
                    dw_d       = dw_eff;
                    word_start = 1'b1;
                    // CPHA=1 presents bit 0 on the first leading edge, so that edge must not shift
                    skip_d     = CPHA;
                end
            end
            ACTIVE: begin
                if (done_q) begin
                    rxdata_d  = rx_sh_q;
                    rxvalid_d = 1'b1;
                    if (rxvalid_q && !RXREADY) begin
                        rxovf_d = 1'b1;
                    end
                    cnt_d   = '0;
                    rx_sh_d = '0;
                end
                if (csb_s) begin
                    state_d = IDLE;
                end else if (done_q) begin
                    // Next word's bit 0 is already on MISO; the next shift edge only marks it
                    word_start = 1'b1;
                    skip_d     = 1'b1;
                end else begin
                    if (sample_edge) begin
                        if (border_q) begin
                            rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
                        end else begin
                            rx_sh_d = (rx_sh_q >> 1) |
                                      ({{(DATA_W-1){1'b0}}, mosi_s} << msb_idx);
                        end
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == dw_q) begin
                            done_d = 1'b1;
                        end
                    end
                    if (shift_edge) begin
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            tx_sh_d = border_q ? (tx_sh_q << 1) : (tx_sh_q >> 1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (word_start) begin
            cnt_d   = '0;
            rx_sh_d = '0;
            if (hold_full_q) begin
                tx_sh_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_sh_d = '0;
                txunf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
        if (!SYSRSTB) begin
            state_q     <= IDLE;
            csb_sync_q  <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csb_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            border_q    <= 1'b0;
            dw_q        <= '0;
            cnt_q       <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            skip_q      <= 1'b0;
            done_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rxdata_q    <= '0;
            rxvalid_q   <= 1'b0;
            rxovf_q     <= 1'b0;
            txunf_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            csb_sync_q  <= csb_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            csb_prev_q  <= csb_prev_d;
            sclk_prev_q <= sclk_prev_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            border_q    <= border_d;
            dw_q        <= dw_d;
            cnt_q       <= cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            skip_q      <= skip_d;
            done_q      <= done_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rxdata_q    <= rxdata_d;
            rxvalid_q   <= rxvalid_d;
            rxovf_q     <= rxovf_d;
            txunf_q     <= txunf_d;
        end
    end

endmodule
